// File: rtl/fifo_serial_reader.sv
// ============================================================================
// fifo_serial_reader
// ----------------------------------------------------------------------------
// Read-side consumer for a show-ahead FIFO. While idle it watches the FIFO's
// empty flag. When it is allowed to start a frame, it pops exactly one word
// with a single-cycle rinc strobe. The popped word is then sent on a
// single-wire asynchronous serial line, in this order:
//   start bit (0), DATA_WIDTH data bits LSB first, optional even parity bit,
//   stop bit (1).
// Each bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters
//   DATA_WIDTH   : FIFO word width and the number of data bits per frame
//   CLKS_PER_BIT : clock cycles per serial bit (must be >= 2)
//   PARITY       : 0 = no parity bit, 1 = even parity bit after the data bits
//
// Ports
//   clk   : single clock; all state changes on the rising edge
//   rst   : asynchronous, active-high reset
//   en    : permits new frames to start; sampled only while idle
//   empty : FIFO empty flag
//   rdata : FIFO head word; valid whenever empty = 0
//   rinc  : registered pop strobe; one cycle per word
//   tx    : registered serial output; idles high
//   busy  : high for the whole frame (F cycles)
//   done  : one-cycle pulse in the first idle cycle after a stop bit
// ============================================================================
module fifo_serial_reader #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    // Counter widths. Each counter is at least one bit wide.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cyc_cnt;
    logic [BW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_bit;

    logic                    bit_end;
    logic                    last_bit;
    logic [DATA_WIDTH-1:0]   shifted;

    always_comb begin
        bit_end  = (cyc_cnt == CYC_LAST);
        last_bit = (bit_idx == BIT_LAST);
        shifted  = shreg >> 1;
    end

    // The registered tx always holds the level of the bit currently on the
    // line. At each bit boundary, tx is loaded with the value of the next bit.
    // Loading it a cycle early in this way is what places the start bit in the
    // same cycle as the rinc pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            rinc    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // rinc and done are single-cycle strobes.
            rinc <= 1'b0;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    cyc_cnt <= '0;
                    bit_idx <= '0;
                    if (en && !empty) begin
                        shreg   <= rdata;
                        // Parity is taken from the word as it was latched,
                        // not from the shift register as it is shifted out.
                        par_bit <= ^rdata;
                        rinc    <= 1'b1;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        shreg   <= shifted;
                        if (last_bit) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= PAR;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                            tx      <= shifted[0];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                PAR: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= 1'b1;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_reader.sv
// ============================================================================
// tb_fifo_serial_reader
// ----------------------------------------------------------------------------
// Two instances of fifo_serial_reader: index 0 has PARITY = 0, index 1 has
// PARITY = 1. Each instance is fed by its own queue-based FIFO model.
//
// Every pushed word is also queued as an expected frame. A monitor for each
// instance works as follows:
//   - It pops the expected word when a pop is due.
//   - It records tx for the length of the frame.
//   - It compares the recording with a waveform built from the framing rules:
//     start bit, LSB-first data, even parity, stop bit, each bit held for
//     CLKS_PER_BIT cycles.
// ============================================================================
module tb_fifo_serial_reader;

    localparam int DW  = 4;
    localparam int CPB = 4;

    typedef logic [DW-1:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en    [2];
    logic          empty [2];
    logic [DW-1:0] rdata [2];
    logic          rinc  [2];
    logic          tx    [2];
    logic          busy  [2];
    logic          done  [2];

    word_q_t fq   [2];   // FIFO contents seen by each DUT
    word_q_t expq [2];   // words still expected on each serial line
    int      ph   [2];   // monitor phase: 0 idle, 1 in frame, 2 done cycle

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Expected tx level for each cycle of one frame. Bit i of the result is
    // the tx level in cycle i of the frame.
    function automatic logic [31:0] exp_wave(input logic [DW-1:0] w,
                                             input int par);
        logic [31:0] v;
        logic        b;
        int unsigned nbits;
        v     = '0;
        nbits = 2 + DW + par;
        for (int unsigned i = 0; i < nbits; i++) begin
            if (i == 0)
                b = 1'b0;
            else if (i <= DW)
                b = w[i-1];
            else if (par != 0 && i == DW + 1)
                b = ^w;
            else
                b = 1'b1;
            for (int unsigned c = 0; c < CPB; c++)
                v[i*CPB + c] = b;
        end
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int FL = (2 + DW + g) * CPB;

        fifo_serial_reader #(
            .DATA_WIDTH  (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY      (g)
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .en   (en[g]),
            .empty(empty[g]),
            .rdata(rdata[g]),
            .rinc (rinc[g]),
            .tx   (tx[g]),
            .busy (busy[g]),
            .done (done[g])
        );

        initial begin : mon
            logic          s_en, s_empty, p;
            logic [31:0]   obs, expw;
            logic [DW-1:0] w;
            int            k;
            ph[g] = 0;
            k     = 0;
            obs   = '0;
            expw  = '0;
            w     = '0;
            forever begin
                @(posedge clk);
                s_en    = en[g];
                s_empty = empty[g];
                #1;
                if (rst) begin
                    // A frame cut short by reset is dropped from the
                    // expectations. Its word was already popped.
                    ph[g] = 0;
                    k     = 0;
                end else if (ph[g] == 0) begin
                    p = s_en && !s_empty;
                    check($sformatf("idle%0d", g),
                          {rinc[g], busy[g], tx[g], done[g]},
                          {p, p, ~p, 1'b0});
                    if (p) begin
                        if (expq[g].size() == 0) begin
                            check($sformatf("pop_underflow%0d", g), 1, 0);
                            w = '0;
                        end else begin
                            w = expq[g].pop_front();
                        end
                        expw   = exp_wave(w, g);
                        obs    = '0;
                        obs[0] = tx[g];
                        k      = 1;
                        ph[g]  = 1;
                    end
                end else if (ph[g] == 1) begin
                    check($sformatf("frame_ctl%0d", g),
                          {rinc[g], busy[g], done[g]}, 3'b010);
                    obs[k] = tx[g];
                    k++;
                    if (k == FL) begin
                        check($sformatf("wave%0d_w%0h", g, w), obs, expw);
                        ph[g] = 2;
                    end
                end else begin
                    check($sformatf("done%0d", g),
                          {rinc[g], busy[g], tx[g], done[g]}, 4'b0011);
                    ph[g] = 0;
                end
            end
        end
    end

    task automatic update_fifo();
        for (int g = 0; g < 2; g++) begin
            empty[g] = (fq[g].size() == 0);
            rdata[g] = (fq[g].size() != 0) ? fq[g][0] : '0;
        end
    endtask

    // Advances to the next falling edge. The model FIFO pops its head when
    // rinc is seen there.
    task automatic tick();
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            if (rinc[g] && fq[g].size() != 0)
                void'(fq[g].pop_front());
        update_fifo();
    endtask

    task automatic push_both(input logic [DW-1:0] w);
        for (int g = 0; g < 2; g++) begin
            fq[g].push_back(w);
            expq[g].push_back(w);
        end
        update_fifo();
    endtask

    task automatic set_en(input logic v);
        en[0] = v;
        en[1] = v;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 600 && !(fq[0].size() == 0 && fq[1].size() == 0 &&
                            expq[0].size() == 0 && expq[1].size() == 0 &&
                            ph[0] == 0 && ph[1] == 0)) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, (n < 600) ? 1 : 0, 1);
        repeat (3) tick();
    endtask

    task automatic wait_rinc(input string name);
        int n;
        n = 0;
        while (n < 100 && !rinc[0]) begin
            tick();
            n++;
        end
        check({name, "_rinc_seen"}, rinc[0], 1);
    endtask

    initial begin
        set_en(1'b0);
        update_fifo();
        rst = 1'b1;
        repeat (3) tick();
        for (int g = 0; g < 2; g++)
            check($sformatf("reset_vals%0d", g),
                  {rinc[g], busy[g], tx[g], done[g]}, 4'b0010);
        rst = 1'b0;

        // Frames are enabled while the FIFO stays empty.
        set_en(1'b1);
        repeat (100) tick();

        // Single word 0xA.
        push_both(4'hA);
        wait_idle("single");

        // Three queued words, sent back to back.
        push_both(4'h1);
        push_both(4'h8);
        push_both(4'hF);
        wait_idle("three");

        // 0x7 is the parity case for instance 1.
        push_both(4'h7);
        wait_idle("parity");

        // en dropped during DATA while words are still pending.
        push_both(4'h3);
        push_both(4'hC);
        push_both(4'h5);
        wait_rinc("endrop");
        repeat (8) tick();
        set_en(1'b0);
        repeat (60) tick();
        check("endrop_pending0", fq[0].size(), 2);
        check("endrop_pending1", fq[1].size(), 2);
        set_en(1'b1);
        wait_idle("endrop");

        // Reset pulsed during data bit 2.
        push_both(4'h9);
        push_both(4'h6);
        wait_rinc("rstmid");
        repeat (13) tick();
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++)
            check($sformatf("rst_async%0d", g),
                  {rinc[g], busy[g], tx[g], done[g]}, 4'b0010);
        repeat (2) tick();
        rst = 1'b0;
        wait_idle("rstmid");

        // Randomized pushes with occasional changes to en.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(7, 0) == 0 && fq[0].size() < 4 &&
                fq[1].size() < 4)
                push_both(DW'($urandom));
            if ($urandom_range(49, 0) == 0)
                set_en(~en[0]);
        end
        set_en(1'b1);
        wait_idle("random");
        check("final_exp_empty0", expq[0].size(), 0);
        check("final_exp_empty1", expq[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
